// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver, oversampled in the pin_clk_12mhz domain.
// Deserialises BCLK/LRCLK/SDATA into parallel left/right PCM samples and
// issues one sample_valid strobe per good stereo frame.
//
// Ports:
//   pin_clk_12mhz  system clock (all logic runs here)
//   rst            asynchronous active-high reset
//   i2s_bclk       I2S bit clock, asynchronous to pin_clk_12mhz
//   i2s_lrclk      I2S word select (0 = left, 1 = right)
//   i2s_sdata      I2S serial data, MSB first
//   left_sample    last complete left sample (left-aligned, SAMPLE_W bits)
//   right_sample   last complete right sample (left-aligned, SAMPLE_W bits)
//   sample_valid   one-cycle strobe; a new left/right pair is presented
//   frame_error    sticky; a slot length fell outside [SLOT_MIN, SLOT_MAX]
//   locked         high once a full left+right frame has been received
//
// Build option: define I2S_RX_LJ_EN for left-justified input (no 1-bit
// delay). Without it the standard I2S 1-bit-delay format is received.
module i2s_rx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_MAX = 32,
  parameter int SLOT_MIN = 16
) (
  input  logic                pin_clk_12mhz,
  input  logic                rst,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                sample_valid,
  output logic                frame_error,
  output logic                locked
);

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_LEFT      = 2'd1;
  localparam logic [1:0] ST_RIGHT     = 2'd2;
  localparam logic [1:0] ST_OUTPUT    = 2'd3;

  localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};
  // idle_cnt reaching this value with no edge marks the 1024th idle clock
  localparam logic [9:0] STALL_LIMIT = 10'd1023;

  // ---------------------------------------------------------------------
  // Pin synchronisers and BCLK rising-edge detection
  // ---------------------------------------------------------------------
  logic [1:0] bclk_sync;
  logic [1:0] lrclk_sync;
  logic [1:0] sdata_sync;
  logic       bclk_prev;

  always_ff @(posedge pin_clk_12mhz or posedge rst) begin
    if (rst) begin
      bclk_sync  <= 2'b00;
      lrclk_sync <= 2'b00;
      sdata_sync <= 2'b00;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], i2s_bclk};
      lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
      sdata_sync <= {sdata_sync[0], i2s_sdata};
      bclk_prev  <= bclk_sync[1];
    end
  end

  logic bclk_rise;
  logic lr_now;
  logic sd_now;
  logic lr_prev;
  logic transition;

  assign bclk_rise  = bclk_sync[1] & ~bclk_prev;
  assign lr_now     = lrclk_sync[1];
  assign sd_now     = sdata_sync[1];
  assign transition = bclk_rise & (lr_now != lr_prev);

  // ---------------------------------------------------------------------
  // BCLK stall watchdog
  // ---------------------------------------------------------------------
  logic [9:0] idle_cnt;
  logic       stall;

  always_ff @(posedge pin_clk_12mhz or posedge rst) begin
    if (rst) begin
      idle_cnt <= 10'd0;
    end else if (bclk_rise) begin
      idle_cnt <= 10'd0;
    end else if (idle_cnt != STALL_LIMIT) begin
      idle_cnt <= idle_cnt + 10'd1;
    end
  end

  assign stall = (idle_cnt == STALL_LIMIT) && !bclk_rise;

  // ---------------------------------------------------------------------
  // Slot shifter datapath
  // ---------------------------------------------------------------------
  logic [1:0]          state;
  logic [SAMPLE_W-1:0] shifter;
  logic [SAMPLE_W-1:0] left_hold;
  logic [5:0]          bit_cnt;

  logic [SAMPLE_W-1:0] shift_in;   // shifter with the current bit placed
  logic [5:0]          cnt_inc;    // saturating bit count + 1
  logic [SAMPLE_W-1:0] close_word; // value of the slot that is closing
  logic [5:0]          close_len;  // length of the slot that is closing
  logic [SAMPLE_W-1:0] open_word;  // shifter contents for the new slot
  logic [5:0]          open_cnt;   // bit count for the new slot
  logic                len_ok;

  always_comb begin
    // The bit lands at position SAMPLE_W-1-bit_cnt; once bit_cnt reaches
    // SAMPLE_W the mask shifts out to zero, so extra bits are discarded
    // and short slots keep zero LSBs.
    shift_in = sd_now ? (shifter | (MSB_ONE >> bit_cnt)) : shifter;
    cnt_inc  = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
`ifdef I2S_RX_LJ_EN
    // Left-justified: the transition bit is the MSB of the new slot.
    close_word = shifter;
    close_len  = bit_cnt;
    open_word  = sd_now ? MSB_ONE : '0;
    open_cnt   = 6'd1;
`else
    // I2S: the transition bit is the LSB of the slot that is ending.
    close_word = shift_in;
    close_len  = cnt_inc;
    open_word  = '0;
    open_cnt   = 6'd0;
`endif
    len_ok = (int'(close_len) >= SLOT_MIN) && (int'(close_len) <= SLOT_MAX);
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge pin_clk_12mhz or posedge rst) begin
    if (rst) begin
      state        <= ST_WAIT_SYNC;
      lr_prev      <= 1'b0;
      shifter      <= '0;
      left_hold    <= '0;
      bit_cnt      <= 6'd0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr_now;
      end

      if (stall) begin
        state  <= ST_WAIT_SYNC;
        locked <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_SYNC: begin
            // Only a right-to-left boundary starts a frame
            if (transition && !lr_now) begin
              shifter <= open_word;
              bit_cnt <= open_cnt;
              state   <= ST_LEFT;
            end
          end

          ST_LEFT, ST_RIGHT: begin
            if (transition) begin
              shifter <= open_word;
              bit_cnt <= open_cnt;
              if (!len_ok) begin
                frame_error <= 1'b1;
                locked      <= 1'b0;
                state       <= ST_WAIT_SYNC;
              end else if (state == ST_LEFT) begin
                left_hold <= close_word;
                state     <= ST_RIGHT;
              end else begin
                // Outputs and strobe register here so they are visible
                // during the single OUTPUT cycle.
                left_sample  <= left_hold;
                right_sample <= close_word;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                state        <= ST_OUTPUT;
              end
            end else if (bclk_rise) begin
              shifter <= shift_in;
              bit_cnt <= cnt_inc;
            end
          end

          default: begin
            // ST_OUTPUT lasts one cycle; the new left slot is already open.
            if (bclk_rise && !transition) begin
              shifter <= shift_in;
              bit_cnt <= cnt_inc;
            end
            state <= ST_LEFT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int W = 24;
  localparam int SMIN = 16;
  localparam int SMAX = 32;
  localparam real BH = 162.76;   // BCLK half period, 3.072 MHz
`ifdef I2S_RX_LJ_EN
  localparam bit RX_LJ = 1'b1;
`else
  localparam bit RX_LJ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bclk = 1'b0;
  logic         lrclk = 1'b1;
  logic         sdata = 1'b0;
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic         sample_valid;
  logic         frame_error;
  logic         locked;

  always #41.667 clk = ~clk;

  i2s_rx dut (
    .pin_clk_12mhz(clk),
    .rst(rst),
    .i2s_bclk(bclk),
    .i2s_lrclk(lrclk),
    .i2s_sdata(sdata),
    .left_sample(left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .frame_error(frame_error),
    .locked(locked)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- monitor ----------------
  longint       cyc = 0;
  logic [W-1:0] got_l[$];
  logic [W-1:0] got_r[$];
  longint       got_c[$];
  int           wide = 0;
  logic         prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_l.push_back(left_sample);
      got_r.push_back(right_sample);
      got_c.push_back(cyc);
      if (prev_v) wide++;
    end
    prev_v <= sample_valid;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stream description ----------------
  int          s_ch[$];
  int          s_len[$];
  int          s_vw[$];
  logic [31:0] s_val[$];
  bit          lr_q[$];
  bit          d_q[$];

  task automatic add_slot(input int ch, input int len, input logic [31:0] val, input int vw);
    s_ch.push_back(ch);
    s_len.push_back(len);
    s_val.push_back(val);
    s_vw.push_back(vw);
  endtask

  // Flatten slots into per-BCLK (lrclk, sdata). In I2S format lrclk leads
  // the data by one bit; in left-justified format they are aligned.
  task automatic build_stream(input bit lj_fmt);
    bit fch[$];
    logic [31:0] v;
    lr_q.delete();
    d_q.delete();
    foreach (s_ch[k]) begin
      v = s_val[k];
      for (int b = 0; b < s_len[k]; b++) begin
        fch.push_back(s_ch[k] != 0);
        d_q.push_back((b < s_vw[k]) ? v[s_vw[k]-1-b] : 1'b0);
      end
    end
    for (int i = 0; i < fch.size(); i++)
      lr_q.push_back(lj_fmt ? fch[i] : ((i + 1 < fch.size()) ? fch[i+1] : fch[i]));
  endtask

  // ---------------- reference model ----------------
  // Slot-level model: split the driven bit stream into slots by the
  // receiver's format rule, then walk the slots with sync/length rules.
  int           m_st;        // 0 unsynced, 1 in left slot, 2 in right slot
  int           m_len;
  logic [W-1:0] m_val;
  logic [W-1:0] m_hl;
  bit           m_err = 0;
  bit           m_lock = 0;
  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_r[$];

  task automatic close_slot(input bit ch);
    bit ok;
    ok = (m_len >= SMIN) && (m_len <= SMAX);
    case (m_st)
      0: if (ch) m_st = 1;
      1: if (!ok) begin m_err = 1; m_lock = 0; m_st = 0; end
         else begin m_hl = m_val; m_st = 2; end
      default: if (!ok) begin m_err = 1; m_lock = 0; m_st = 0; end
         else begin exp_l.push_back(m_hl); exp_r.push_back(m_val); m_lock = 1; m_st = 1; end
    endcase
    m_len = 0;
    m_val = '0;
  endtask

  task automatic predict();
    bit tr;
    m_st = 0;
    m_len = 0;
    m_val = '0;
    for (int i = 0; i < lr_q.size(); i++) begin
      tr = (i > 0) && (lr_q[i] != lr_q[i-1]);
      if (tr && RX_LJ) close_slot(lr_q[i-1]);
      if (m_len < W) m_val[W-1-m_len] = d_q[i];
      m_len++;
      if (tr && !RX_LJ) close_slot(lr_q[i-1]);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < lr_q.size(); i++) begin
      bclk = 1'b0;
      lrclk = lr_q[i];
      sdata = d_q[i];
      #(BH);
      bclk = 1'b1;
      #(BH);
    end
    bclk = 1'b0;
  endtask

  task automatic run_segment(input string tag, input bit lj_fmt);
    int n;
    got_l.delete(); got_r.delete(); got_c.delete();
    exp_l.delete(); exp_r.delete();
    build_stream(lj_fmt);
    predict();
    drive();
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, got_l.size(), exp_l.size());
    n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_left%0d", tag, k), got_l[k], exp_l[k]);
      chk($sformatf("%s_right%0d", tag, k), got_r[k], exp_r[k]);
    end
    chk({tag, "_frame_error"}, frame_error, m_err);
    chk({tag, "_locked"}, locked, m_lock);
    chk({tag, "_strobe_width"}, wide, 0);
    s_ch.delete(); s_len.delete(); s_val.delete(); s_vw.delete();
  endtask

  // Hold BCLK idle long enough for the receiver to drop back to unsynced.
  task automatic idle_unsync();
    repeat (1100) @(negedge clk);
    m_lock = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_err = 0;
    m_lock = 0;
  endtask

  initial begin : main
    int bad_period;
    int cnt;
    int len;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    chk("rst_left", left_sample, 0);
    chk("rst_right", right_sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_locked", locked, 0);
    do_reset();
    repeat (5) @(negedge clk);

    // ---- 32-bit slots, fixed pattern, strobe spacing ----
    add_slot(1, 10, $urandom, 10);
    for (int f = 0; f < 4; f++) begin
      add_slot(0, 32, 32'h123456, 24);
      add_slot(1, 32, 32'hABCDEF, 24);
    end
    add_slot(0, 4, 32'h5, 4);
    run_segment("fix32", RX_LJ);
    if (got_l.size() > 0) begin
      chk("fix32_left_const", got_l[0], 24'h123456);
      chk("fix32_right_const", got_r[0], 24'hABCDEF);
    end
    bad_period = 0;
    for (int k = 1; k < got_c.size(); k++)
      if (got_c[k] - got_c[k-1] < 249 || got_c[k] - got_c[k-1] > 251) bad_period++;
    chk("fix32_period", bad_period, 0);

    // ---- BCLK stall: locked drops near 1024 idle clocks ----
    cnt = 0;
    while (locked === 1'b1 && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    chk("stall_locked_drop", (cnt >= 1000 && cnt <= 1030), 1);
    repeat (2000 - cnt) @(negedge clk);
    chk("stall_frame_error", frame_error, 0);
    chk("stall_locked_low", locked, 0);
    m_lock = 0;

    // ---- 16-bit slots, restart after stall ----
    add_slot(1, 7, $urandom, 7);
    for (int f = 0; f < 3; f++) begin
      add_slot(0, 16, 32'h8001, 16);
      add_slot(1, 16, 32'h7FFE, 16);
    end
    add_slot(0, 3, 32'h0, 3);
    run_segment("s16", RX_LJ);
    if (got_l.size() > 0) begin
      chk("s16_left_const", got_l[0], 24'h800100);
      chk("s16_right_const", got_r[0], 24'h7FFE00);
    end
    idle_unsync();

    // ---- random lengths and data, including both length limits ----
    add_slot(1, 12, $urandom, 12);
    add_slot(0, 16, $urandom, 16);
    add_slot(1, 32, $urandom, 32);
    add_slot(0, 32, $urandom, 32);
    add_slot(1, 16, $urandom, 16);
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(SMAX, SMIN);
      add_slot(0, len, $urandom, len);
      len = $urandom_range(SMAX, SMIN);
      add_slot(1, len, $urandom, len);
    end
    add_slot(0, 5, $urandom, 5);
    run_segment("rand", RX_LJ);
    idle_unsync();

    // ---- oversized slot: error, locked drops, no strobe ----
    add_slot(1, 9, $urandom, 9);
    add_slot(0, 32, $urandom, 32);
    add_slot(1, 32, $urandom, 32);
    add_slot(0, 40, $urandom, 32);
    add_slot(1, 5, $urandom, 5);
    run_segment("err_a", RX_LJ);
    idle_unsync();

    // ---- oversized slot mid-stream, then resync ----
    add_slot(1, 9, $urandom, 9);
    add_slot(0, 32, $urandom, 32);
    add_slot(1, 32, $urandom, 32);
    add_slot(0, 40, $urandom, 32);
    add_slot(1, 32, $urandom, 32);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, 32, $urandom, 32);
      add_slot(1, 32, $urandom, 32);
    end
    add_slot(0, 4, $urandom, 4);
    run_segment("err_b", RX_LJ);
    idle_unsync();

    // ---- reset in the middle of a right slot ----
    add_slot(1, 8, $urandom, 8);
    add_slot(0, 32, $urandom, 32);
    add_slot(1, 32, $urandom, 32);
    add_slot(0, 32, $urandom, 32);
    add_slot(1, 12, $urandom, 12);
    run_segment("pre_rst", RX_LJ);
    rst = 1'b1;
    #5;
    chk("midrst_left", left_sample, 0);
    chk("midrst_right", right_sample, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_frame_error", frame_error, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_err = 0;
    m_lock = 0;
    add_slot(1, 20, $urandom, 20);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, 32, $urandom, 32);
      add_slot(1, 32, $urandom, 32);
    end
    add_slot(0, 4, $urandom, 4);
    run_segment("post_rst", RX_LJ);
    idle_unsync();

    // ---- left-justified stream: exact in LJ build, 1-bit shift in I2S ----
    add_slot(1, 10, $urandom, 10);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, 32, 32'hA5A5A5, 24);
      add_slot(1, 32, 32'h5A5A5A, 24);
    end
    add_slot(0, 4, 32'h0, 4);
    run_segment("ljfmt", 1'b1);
    if (got_l.size() > 0) begin
      chk("ljfmt_left_const", got_l[0], RX_LJ ? 24'hA5A5A5 : 24'h4B4B4A);
      chk("ljfmt_right_const", got_r[0], RX_LJ ? 24'h5A5A5A : 24'hB4B4B4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin : watchdog
    #8ms;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver that deserialises an external I2S stream (BCLK/LRCLK/SDATA) into parallel left/right PCM samples.
- Sits directly upstream of the splitstreamer/S/PDIF encoder path and delivers one stereo sample pair per frame, marked by a single-cycle valid strobe.
- All logic runs in the 12 MHz system clock domain. The I2S pins are oversampled (about 3.9x at 48 kHz × 64 BCLK).

Parameters:
- SAMPLE_W, 24, width of output samples in bits.
- SLOT_MAX, 32, maximum legal bits per slot; longer slots flag an error.
- SLOT_MIN, 16, minimum legal bits per slot; shorter slots flag an error.

Ports:
- pin_clk_12mhz  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- i2s_bclk  input  1  I2S bit clock, asynchronous to pin_clk_12mhz
- i2s_lrclk  input  1  I2S word select; 0 = left, 1 = right
- i2s_sdata  input  1  I2S serial data, MSB first
- left_sample  output  SAMPLE_W  last complete left sample
- right_sample  output  SAMPLE_W  last complete right sample
- sample_valid  output  1  one-cycle strobe; new left/right pair is valid
- frame_error  output  1  sticky; slot length was out of range
- locked  output  1  high once the first full left+right frame has been received

Behaviour:
- Reset: the clock is pin_clk_12mhz; reset is asynchronous and active-high on rst. While rst is high, all outputs are 0 and the state is WAIT_SYNC. Asserting rst mid-slot discards the partial data immediately.
- Input sync: bclk, lrclk and sdata each pass through a 2-FF synchroniser.
  - The BCLK rising edge is detected from the synchronised bclk (previous=0, current=1).
  - Lrclk and sdata are sampled in that same cycle.
  - Pin-to-detect latency is 3 clocks.
- Lr_prev holds the lrclk value seen at the previous BCLK rising edge. A "transition edge" is a BCLK rising edge where the sampled lrclk differs from lr_prev.
- I2S format (1-bit delay): the bit sampled on a transition edge is the LSB of the slot that is ending. It is shifted into that slot, and then the slot closes.
- Shift rule:
  - The first SAMPLE_W bits of a slot are shifted in MSB-first.
  - Bits beyond SAMPLE_W are counted but discarded.
  - A slot shorter than SAMPLE_W is left-aligned, with zero-padded LSBs.
- Bit counter: 6 bits. It saturates at 63 and resets to 0 after each slot closes.
- States:
  - WAIT_SYNC: ignore data. On a transition edge with lrclk 1→0, go to LEFT.
  - LEFT: shift bits. On a transition edge (0→1), latch the shifter into the left holding register, check the slot length, go to RIGHT.
  - RIGHT: shift bits. On a transition edge (1→0), latch the right register, check the slot length, go to OUTPUT.
  - OUTPUT: one cycle.
    - left_sample/right_sample update together.
    - sample_valid=1 for exactly this cycle.
    - locked=1.
    - Return to LEFT. A BCLK edge cannot occur within that cycle, since BCLK ≤ 6 MHz, so no data is lost.
- Latency: sample_valid rises 1 clock after the closing transition edge is detected. Outputs hold their values between strobes.
- Slot length check:
  - The length counts every bit of the slot, including the transition-edge bit.
  - A length outside [SLOT_MIN, SLOT_MAX] sets frame_error, which is sticky until rst.
  - On an error, the state returns to WAIT_SYNC and locked clears. No sample_valid is issued for that frame.
- BCLK stall: if no BCLK edge arrives for 1024 clocks, go to WAIT_SYNC and clear locked. frame_error is not set.
- Partial first slot: data before the first 1→0 lrclk transition is never output.

Optional Feature:
- Macro: I2S_RX_LJ_EN.
- Defined: left-justified format, no 1-bit delay. The bit sampled on a transition edge is the MSB of the new slot, and the slot closes before that bit is shifted.
- Undefined: standard I2S 1-bit delay, as described above.
- Only the shift/close ordering differs. The states, lengths and strobe timing are the same in both modes.

Test Plan:
- Reset with BCLK at 3.072 MHz, 32-bit slots, left=0x123456, right=0xABCDEF (24 bits, 8 zero LSBs per slot) → after sync, the first completed frame gives sample_valid for one clock with left_sample=0x123456, right_sample=0xABCDEF, locked=1. Strobes then repeat every 250±1 clocks.
- 16-bit slots, left=0x8001, right=0x7FFE → left_sample=0x800100, right_sample=0x7FFE00, no frame_error.
- One 40-bit slot injected mid-stream → frame_error=1 and stays 1, locked=0, no strobe for that frame. Valid strobes resume after the next 1→0 resync.
- BCLK held low for 2000 clocks, then restarted → locked falls at about 1024 clocks idle, frame_error stays 0, and output resumes after one full frame.
- rst pulsed mid-right-slot → outputs 0 immediately. The next sample_valid carries only a full post-reset frame and never mixes pre-reset bits.
- With I2S_RX_LJ_EN defined, stream left-justified left=0xA5A5A5, right=0x5A5A5A → outputs match exactly. The same stream without the macro gives values shifted by one bit, confirming format selection.
